// File: rtl/clk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_ctrl_pkg
// Shared definitions for the CPU clock sequencing controller:
//   - mode encodings driven from the board switches
//   - FSM state encoding
//   - calc_def_lim(): default half-period length from the input and target
//     frequencies (result clamped to at least one cycle)
// ---------------------------------------------------------------------------
package clk_ctrl_pkg;

   localparam logic [1:0] MODE_HALT  = 2'b00;
   localparam logic [1:0] MODE_RUN   = 2'b01;
   localparam logic [1:0] MODE_STEP  = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STEP  = 2'd2,
      BURST = 2'd3
   } state_t;

   // Half-period in input clock cycles; a zero result (or zero target
   // frequency) would stall the divider, so it is clamped to one.
   function automatic logic [31:0] calc_def_lim(input int unsigned clk_freq,
                                                input int unsigned def_freq);
      int unsigned lim;
      if (def_freq == 32'd0) begin
         lim = 32'd1;
      end else begin
         lim = clk_freq / 32'd2 / def_freq;
      end
      if (lim == 32'd0) begin
         lim = 32'd1;
      end else begin
         lim = lim;
      end
      return lim;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// Two-flop synchroniser followed by a registered rising-edge detector for an
// asynchronous (already debounced) board input.  A 0->1 change on i_async
// produces a one-cycle o_rise pulse visible three i_clk cycles later.
// Ports:
//   i_clk    - system clock
//   i_rst_n  - synchronous active-low reset
//   i_async  - asynchronous level input
//   o_rise   - registered one-cycle pulse on each rising edge of i_async
// ---------------------------------------------------------------------------
module edge_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync2_d;
   logic r_rise;

   // Synchroniser chain and registered edge detect.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_sync2_d <= 1'b0;
         r_rise    <= 1'b0;
      end else begin
         r_sync1   <= i_async;
         r_sync2   <= r_sync1;
         r_sync2_d <= r_sync2;
         r_rise    <= r_sync2 & ~r_sync2_d;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/clk_ctrl.sv
// ---------------------------------------------------------------------------
// clk_ctrl
// Generates the experiment CPU clock from clkin.  Only whole periods are
// ever produced: a period is lim cycles high followed by lim cycles low, and
// mode changes / step requests are acted on only between periods.
// Ports:
//   clkin      - system clock
//   rst        - synchronous active-low reset
//   mode       - 00 halt, 01 free-run, 10 single-step, 11 N-pulse burst
//   step_btn   - asynchronous debounced step push-button
//   div_cfg    - requested half-period in clkin cycles (0 ignored)
//   cfg_load   - one-cycle strobe capturing div_cfg
//   burst_len  - number of full periods per burst
//   clkout     - generated clock (registered)
//   clk_rise   - one-cycle pulse in the cycle clkout goes 0->1
//   busy       - high while a period is in progress or RUN is active
//   pulse_cnt  - count of clkout rising edges, wraps modulo 2^32
// ---------------------------------------------------------------------------
module clk_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int unsigned CLK_FREQ_IN = 50000000,
   parameter int unsigned DEF_FREQ    = 1000,
   parameter int unsigned BURST_W     = 16
)(
   input  logic               clkin,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic               step_btn,
   input  logic [31:0]        div_cfg,
   input  logic               cfg_load,
   input  logic [BURST_W-1:0] burst_len,
   output logic               clkout,
   output logic               clk_rise,
   output logic               busy,
   output logic [31:0]        pulse_cnt
);

   localparam logic [31:0] DEF_LIM = calc_def_lim(CLK_FREQ_IN, DEF_FREQ);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [31:0]        r_cnt;
   logic [31:0]        r_lim;
   logic [31:0]        r_pend;
   logic               r_pend_vld;
   logic [BURST_W-1:0] r_brem;
   logic               r_armed;
   logic               r_clkout;
   logic               r_clk_rise;
   logic               r_busy;
   logic [31:0]        r_pulse_cnt;

   logic               w_step_req;
   logic               w_phase_end;
   logic               w_period_end;
   logic               w_start;
   logic               w_brem_load;
   logic               w_brem_dec;
   logic               w_armed_set;
   logic               w_armed_clr;

   edge_sync u_step_sync (
      .i_clk   (clkin),
      .i_rst_n (rst),
      .i_async (step_btn),
      .o_rise  (w_step_req)
   );

   assign w_phase_end  = (r_cnt == (r_lim - 32'd1));
   // A period ends on the last cycle of its low phase.
   assign w_period_end = w_phase_end && !r_clkout && (r_state != IDLE);

   // Next-state and start decision; a start makes clkout rise next cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_brem_load = 1'b0;
      w_brem_dec  = 1'b0;
      w_armed_set = 1'b0;
      w_armed_clr = 1'b0;
      case (r_state)
         IDLE: begin
            // Leaving burst mode re-arms it, so each entry fires once.
            w_armed_set = (mode != MODE_BURST);
            case (mode)
               MODE_RUN: begin
                  w_start     = 1'b1;
                  w_state_nxt = RUN;
               end
               MODE_STEP: begin
                  if (w_step_req) begin
                     w_start     = 1'b1;
                     w_state_nxt = STEP;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
               MODE_BURST: begin
                  w_armed_clr = 1'b1;
                  if (r_armed && (burst_len != {BURST_W{1'b0}})) begin
                     w_brem_load = 1'b1;
                     w_start     = 1'b1;
                     w_state_nxt = BURST;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
               default: begin
                  w_state_nxt = IDLE;
               end
            endcase
         end
         RUN: begin
            if (w_period_end) begin
               if (mode == MODE_RUN) begin
                  w_start = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_state_nxt = RUN;
            end
         end
         STEP: begin
            if (w_period_end) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = STEP;
            end
         end
         BURST: begin
            if (w_period_end) begin
               if (r_brem != {BURST_W{1'b0}}) begin
                  w_brem_dec = 1'b1;
                  w_start    = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_state_nxt = BURST;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register and busy flag (busy tracks the state being entered).
   always_ff @(posedge clkin) begin
      if (!rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != IDLE);
      end
   end

   // Divide counter, clkout generation and rising-edge bookkeeping.
   always_ff @(posedge clkin) begin
      if (!rst) begin
         r_clkout    <= 1'b0;
         r_clk_rise  <= 1'b0;
         r_cnt       <= 32'd0;
         r_pulse_cnt <= 32'd0;
         r_lim       <= DEF_LIM;
      end else begin
         r_clk_rise <= w_start;
         if (w_start) begin
            // clkout is low here, so a new limit never cuts a phase short.
            r_clkout    <= 1'b1;
            r_cnt       <= 32'd0;
            r_pulse_cnt <= r_pulse_cnt + 32'd1;
            if (r_pend_vld) begin
               r_lim <= r_pend;
            end else begin
               r_lim <= r_lim;
            end
         end else if (r_state != IDLE) begin
            // Phase end either drops the high phase or closes the period.
            if (w_phase_end) begin
               r_clkout <= 1'b0;
               r_cnt    <= 32'd0;
            end else begin
               r_cnt <= r_cnt + 32'd1;
            end
         end else begin
            r_clkout <= 1'b0;
            r_cnt    <= 32'd0;
         end
      end
   end

   // Pending limit capture; consumed at the next period start.
   always_ff @(posedge clkin) begin
      if (!rst) begin
         r_pend     <= 32'd0;
         r_pend_vld <= 1'b0;
      end else if (cfg_load && (div_cfg != 32'd0)) begin
         r_pend     <= div_cfg;
         r_pend_vld <= 1'b1;
      end else if (w_start) begin
         r_pend_vld <= 1'b0;
      end else begin
         r_pend_vld <= r_pend_vld;
      end
   end

   // Burst remaining counter and one-shot arming flag.
   always_ff @(posedge clkin) begin
      if (!rst) begin
         r_brem  <= {BURST_W{1'b0}};
         r_armed <= 1'b0;
      end else begin
         if (w_brem_load) begin
            r_brem <= burst_len - BURST_W'(1);
         end else if (w_brem_dec) begin
            r_brem <= r_brem - BURST_W'(1);
         end else begin
            r_brem <= r_brem;
         end
         if (w_armed_clr) begin
            r_armed <= 1'b0;
         end else if (w_armed_set) begin
            r_armed <= 1'b1;
         end else begin
            r_armed <= r_armed;
         end
      end
   end

   assign clkout    = r_clkout;
   assign clk_rise  = r_clk_rise;
   assign busy      = r_busy;
   assign pulse_cnt = r_pulse_cnt;

endmodule
